// File: rtl/shared_adder_if.sv
// Requester-side handshake and result bus of the shared adder scheduler.
// The master modport is the two-requester client side; slave is the scheduler.
interface shared_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             cin0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;
  logic             done_id;

  modport master (
    output req0, a0, b0, cin0,
    output req1, a1, b1, cin1,
    input  ack0, ack1, busy, sum, cout, done, done_id
  );

  modport slave (
    input  req0, a0, b0, cin0,
    input  req1, a1, b1, cin1,
    output ack0, ack1, busy, sum, cout, done, done_id
  );
endinterface

// File: rtl/shared_adder_sched.sv
// Two-client scheduler around one CHUNK-bit adder slice: round-robin grant, then a
// WIDTH-bit add over WIDTH/CHUNK cycles with the carry held in a register.
module shared_adder_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input logic           clk,
  input logic           rst,
  shared_adder_if.slave bus
);
  localparam int unsigned NCH     = WIDTH / CHUNK;
  localparam int unsigned CntW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_id_q, done_id_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             any_req;
  logic             grant;
  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] psum_next;

  // Contention goes to the pointer owner; otherwise the lone requester wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    grant   = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
  end

  // Operands shift right each step, so the slice always sees the next chunk in the
  // low bits; its sum enters the partial-sum register from the top.
  always_comb begin
    slice     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    psum_next = (psum_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    psum_d    = psum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    done_id_d = done_id_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StCalc;
          id_d    = grant;
          ptr_d   = ~grant;
          a_d     = grant ? bus.a1 : bus.a0;
          b_d     = grant ? bus.b1 : bus.b0;
          carry_d = grant ? bus.cin1 : bus.cin0;
          cnt_d   = '0;
          psum_d  = '0;
          ack0_d  = ~grant;
          ack1_d  = grant;
          busy_d  = 1'b1;
        end
      end

      StCalc: begin
        busy_d  = 1'b1;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        psum_d  = psum_next;
        carry_d = slice[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d   = StDone;
          done_d    = 1'b1;
          sum_d     = psum_next;
          cout_d    = slice[CHUNK];
          done_id_d = id_q;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      psum_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_id_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      psum_q    <= psum_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      done_id_q <= done_id_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.busy    = busy_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
endmodule

// File: tb/tb_shared_adder_sched.sv
// Bench for shared_adder_sched: three instances (CHUNK 2, 1, 8) run the same operation
// lists against a per-instance transaction model, plus literal checks on logged results.
module tb_shared_adder_sched;
  localparam int unsigned W  = 8;
  localparam int          NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] op_a   [2][512];
  logic [W-1:0] op_b   [2][512];
  logic         op_c   [2][512];
  int           op_gap [2][512];
  int           nops   [2] = '{0, 0};

  // {ack0, ack1, busy, done, done_id, cout, sum}
  logic [13:0] outs     [NI];
  logic        fin      [NI];
  logic [1:0]  ack_log  [NI][16];
  int          n_ack    [NI] = '{0, 0, 0};
  logic [9:0]  done_log [NI][16];
  int          n_done   [NI] = '{0, 0, 0};

  function automatic logic pick(logic r0, logic r1, logic p);
    return (r0 && r1) ? p : r1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_op(int r, logic [W-1:0] a, logic [W-1:0] b, logic c, int gap);
    op_a[r][nops[r]]   = a;
    op_b[r][nops[r]]   = b;
    op_c[r][nops[r]]   = c;
    op_gap[r][nops[r]] = gap;
    nops[r]++;
  endtask

  task automatic wait_all(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fin[0] && fin[1] && fin[2]) && n < 20000);
    chk({name, " drained"}, {31'd0, fin[0] && fin[1] && fin[2]}, 32'd1);
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int unsigned CH  = (gi == 0) ? 2 : (gi == 1) ? 1 : 8;
    localparam int          NCH = W / CH;

    shared_adder_if #(.WIDTH(W)) bus ();
    shared_adder_sched #(.WIDTH(W), .CHUNK(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Requester agents: present queued ops, hold until ack, then move on.
    for (genvar r = 0; r < 2; r++) begin : ag
      logic         req_r = 1'b0;
      logic [W-1:0] a_r   = '0;
      logic [W-1:0] b_r   = '0;
      logic         cin_r = 1'b0;
      int           idx   = 0;
      wire          ack_r = (r == 0) ? bus.ack0 : bus.ack1;

      initial begin
        int wait_n = -1;
        forever begin
          @(posedge clk);
          #1;
          if (req_r && ack_r) begin
            idx++;
            req_r = 1'b0;
          end
          if (!req_r && idx < nops[r]) begin
            if (wait_n < 0) wait_n = op_gap[r][idx];
            if (wait_n == 0) begin
              req_r  = 1'b1;
              a_r    = op_a[r][idx];
              b_r    = op_b[r][idx];
              cin_r  = op_c[r][idx];
              wait_n = -1;
            end else begin
              wait_n--;
            end
          end
        end
      end
    end

    assign bus.req0 = ag[0].req_r;
    assign bus.a0   = ag[0].a_r;
    assign bus.b0   = ag[0].b_r;
    assign bus.cin0 = ag[0].cin_r;
    assign bus.req1 = ag[1].req_r;
    assign bus.a1   = ag[1].a_r;
    assign bus.b1   = ag[1].b_r;
    assign bus.cin1 = ag[1].cin_r;
    assign outs[gi] = {bus.ack0, bus.ack1, bus.busy, bus.done, bus.done_id, bus.cout, bus.sum};

    // Transaction model: ph counts edges since the grant (0 = idle).
    int         ph     = 0;
    logic       ptr    = 1'b0;
    logic       gid    = 1'b0;
    logic [W:0] cap    = '0;
    logic [W-1:0] e_sum = '0;
    logic       e_cout = 1'b0;
    logic       e_id   = 1'b0;

    assign fin[gi] = (ag[0].idx == nops[0]) && (ag[1].idx == nops[1]) && (ph == 0) &&
                     !ag[0].req_r && !ag[1].req_r;

    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = 0; ptr = 1'b0; gid = 1'b0; e_sum = '0; e_cout = 1'b0; e_id = 1'b0;
      end else if (ph == 0) begin
        if (bus.req0 || bus.req1) begin
          gid = pick(bus.req0, bus.req1, ptr);
          ptr = !gid;
          cap = gid ? ({1'b0, bus.a1} + {1'b0, bus.b1} + {{W{1'b0}}, bus.cin1})
                    : ({1'b0, bus.a0} + {1'b0, bus.b0} + {{W{1'b0}}, bus.cin0});
          ph  = 1;
        end
      end else if (ph <= NCH) begin
        ph++;
        if (ph == NCH + 1) begin
          {e_cout, e_sum} = cap;
          e_id = gid;
        end
      end else begin
        ph = 0;
      end
    end

    initial forever begin
      logic [13:0] exp;
      @(negedge clk);
      exp = {ph == 1 && !gid, ph == 1 && gid, ph != 0, ph == NCH + 1, e_id, e_cout, e_sum};
      n_cmp++;
      if (outs[gi] !== exp) begin
        n_fail++;
        $display("FAIL cycle inst%0d t=%0t: got %h, expected %h", gi, $time, outs[gi], exp);
      end
      if (outs[gi][13] || outs[gi][12]) begin
        if (n_ack[gi] < 16) ack_log[gi][n_ack[gi]] = {1'b0, outs[gi][12]};
        n_ack[gi]++;
      end
      if (outs[gi][10]) begin
        if (n_done[gi] < 16) done_log[gi][n_done[gi]] = outs[gi][9:0];
        n_done[gi]++;
      end
    end
  end

  initial begin
    logic [1:0] exp_ack  [9] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    logic [9:0] exp_done [8] = '{10'h096, 10'h300, 10'h003, 10'h300,
                                 10'h003, 10'h300, 10'h031, 10'h300};
    int n;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    add_op(0, 8'h5A, 8'h3C, 1'b0, 1);
    wait_all("single");
    add_op(1, 8'hFF, 8'h00, 1'b1, 0);
    wait_all("ripple");
    add_op(0, 8'h01, 8'h02, 1'b0, 0);
    add_op(0, 8'h01, 8'h02, 1'b0, 0);
    add_op(1, 8'h80, 8'h80, 1'b0, 0);
    add_op(1, 8'h80, 8'h80, 1'b0, 0);
    wait_all("contention");

    // Async reset while idle with a nonzero held result.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("idle async reset", {18'd0, outs[i]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the second CALC cycle drops the op; both then request, 0 wins.
    add_op(0, 8'h5A, 8'h3C, 1'b0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!outs[0][13] && n < 50);
    chk("ack before mid-op reset", {31'd0, outs[0][13]}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("calc async reset", {18'd0, outs[i]}, 32'd0);
    add_op(0, 8'h10, 8'h20, 1'b1, 0);
    add_op(1, 8'h0F, 8'hF1, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_all("after reset");

    for (int k = 0; k < 100; k++) begin
      add_op(0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      add_op(1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    wait_all("random");

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 9; k++) chk($sformatf("inst%0d ack order %0d", i, k),
                                      {30'd0, ack_log[i][k]}, {30'd0, exp_ack[k]});
      for (int k = 0; k < 8; k++) chk($sformatf("inst%0d result %0d", i, k),
                                      {22'd0, done_log[i][k]}, {22'd0, exp_done[k]});
      chk($sformatf("inst%0d done count", i), n_done[i], 32'd208);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
